// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures synchronized pulse high time and recovers the
// 8-bit angle code with counters only; flags bad pulse widths and loss of signal.
module servo_pwm_decoder #(
    parameter int unsigned FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       servo_pwm,
    output logic [7:0] angle,
    output logic       angle_valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int unsigned CW               = 32;
    localparam int unsigned CYCLES_1_MS      = FREQ / 1_000;
    localparam int unsigned CYCLES_PER_ANGLE = (CYCLES_1_MS * 2) / 255;
    localparam int unsigned MIN_PULSE        = CYCLES_1_MS * 2 / 3;
    localparam int unsigned SHORT_LIMIT      = CYCLES_1_MS / 2;
    localparam int unsigned LONG_LIMIT       = CYCLES_1_MS * 3;
    localparam int unsigned PERIOD_TIMEOUT   = CYCLES_1_MS * 25;
    // Starting the angle count half an LSB early turns truncation into round-to-nearest.
    localparam int unsigned OFFSET_LIMIT     = MIN_PULSE - CYCLES_PER_ANGLE / 2;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        OFFSET,
        ACCUM
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, sync3;
    logic          s, rise, fall;
    logic [CW-1:0] high_cnt, high_nxt;
    logic [CW-1:0] sub_cnt, sub_nxt;
    logic [CW-1:0] per_cnt, per_nxt;
    logic [7:0]    acc, acc_nxt;
    logic [7:0]    angle_nxt;
    logic          valid_nxt, err_nxt, lost_nxt;

    // Synchronizer resets high so a pin already high at reset release never looks like a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= servo_pwm;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign s    = sync2;
    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOW;
            high_cnt    <= '0;
            sub_cnt     <= '0;
            per_cnt     <= '0;
            acc         <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            pulse_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            state       <= state_nxt;
            high_cnt    <= high_nxt;
            sub_cnt     <= sub_nxt;
            per_cnt     <= per_nxt;
            acc         <= acc_nxt;
            angle       <= angle_nxt;
            angle_valid <= valid_nxt;
            pulse_err   <= err_nxt;
            signal_lost <= lost_nxt;
        end
    end

    // high_cnt holds the number of high cycles seen before the current one, so it equals H on the falling-edge cycle.
    always_comb begin
        state_nxt = state;
        high_nxt  = high_cnt;
        sub_nxt   = sub_cnt;
        acc_nxt   = acc;
        angle_nxt = angle;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            WAIT_LOW: begin
                if (!s) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_nxt = OFFSET;
                    high_nxt  = CW'(1);
                end
            end
            OFFSET: begin
                if (fall) begin
                    state_nxt = IDLE;
                    if (high_cnt < CW'(SHORT_LIMIT)) begin
                        err_nxt = 1'b1;
                    end else begin
                        valid_nxt = 1'b1;
                        angle_nxt = 8'd0;
                    end
                end else begin
                    high_nxt = high_cnt + CW'(1);
                    if (high_cnt == CW'(OFFSET_LIMIT - 1)) begin
                        state_nxt = ACCUM;
                        sub_nxt   = '0;
                        acc_nxt   = '0;
                    end
                end
            end
            ACCUM: begin
                if (fall) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b1;
                    angle_nxt = acc;
                end else if (high_cnt == CW'(LONG_LIMIT)) begin
                    state_nxt = WAIT_LOW;
                    err_nxt   = 1'b1;
                end else begin
                    high_nxt = high_cnt + CW'(1);
                    if (sub_cnt == CW'(CYCLES_PER_ANGLE - 1)) begin
                        sub_nxt = '0;
                        if (acc != 8'hFF) begin
                            acc_nxt = acc + 8'd1;
                        end
                    end else begin
                        sub_nxt = sub_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = WAIT_LOW;
            end
        endcase
    end

    // Period watchdog: the rising-edge cycle counts as cycle 1, so loss flags PERIOD_TIMEOUT cycles after the edge.
    always_comb begin
        per_nxt  = per_cnt;
        lost_nxt = signal_lost;
        if (rise) begin
            per_nxt = CW'(1);
        end else if (per_cnt != CW'(PERIOD_TIMEOUT)) begin
            per_nxt = per_cnt + CW'(1);
        end
        if (valid_nxt) begin
            lost_nxt = 1'b0;
        end
        if (per_nxt == CW'(PERIOD_TIMEOUT)) begin
            lost_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder at FREQ=800 kHz: 1 ms = 800 cycles, LSB = 6 cycles,
// MIN_PULSE = 533, SHORT = 400, LONG = 2400, PERIOD_TIMEOUT = 20000, 22 ms = 17600 cycles.
module tb_servo_pwm_decoder;

    logic       clk;
    logic       rst;
    logic       servo_pwm;
    logic [7:0] angle;
    logic       angle_valid;
    logic       pulse_err;
    logic       signal_lost;

    int checks = 0;
    int errors = 0;

    int         nv, ne, lat, nb;
    logic [7:0] ang;
    logic       lv;

    servo_pwm_decoder #(.FREQ(800_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .servo_pwm  (servo_pwm),
        .angle      (angle),
        .angle_valid(angle_valid),
        .pulse_err  (pulse_err),
        .signal_lost(signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one pulse of h cycles then 12 low cycles, recording what the outputs did.
    task automatic drive_pulse(input int h, output int n_valid, output int n_err, output int v_lat,
                               output logic [7:0] a, output logic lost_at_valid, output int n_both);
        n_valid = 0; n_err = 0; v_lat = -1; n_both = 0; lost_at_valid = signal_lost;
        servo_pwm = 1'b1;
        for (int i = 1; i <= h + 12; i++) begin
            step();
            if (i == h) servo_pwm = 1'b0;
            if (angle_valid) n_valid++;
            if (pulse_err) n_err++;
            if (angle_valid && pulse_err) n_both++;
            if (angle_valid && v_lat < 0) begin
                v_lat = i - h;
                lost_at_valid = signal_lost;
            end
        end
        a = angle;
    endtask

    task automatic test_reset();
        servo_pwm = 1'b0;
        rst = 1'b1;
        step(); step(); step();
        checks++; if (angle !== 8'd0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", angle); end
        checks++; if (angle_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", angle_valid); end
        checks++; if (pulse_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", pulse_err); end
        checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL reset_lost: got %0b expected 1", signal_lost); end
        rst = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_min_pulse();
        checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL min_lost_before: got %0b expected 1", signal_lost); end
        drive_pulse(533, nv, ne, lat, ang, lv, nb);
        checks++; if (nv !== 1) begin errors++; $display("FAIL min_valid_count: got %0d expected 1", nv); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL min_valid_latency: got %0d expected 3", lat); end
        checks++; if (ang !== 8'd0) begin errors++; $display("FAIL min_angle: got %0d expected 0", ang); end
        checks++; if (lv !== 1'b0) begin errors++; $display("FAIL min_lost_at_valid: got %0b expected 0", lv); end
        checks++; if (ne !== 0) begin errors++; $display("FAIL min_err_count: got %0d expected 0", ne); end
    endtask

    task automatic test_rounding();
        int         hs [4];
        logic [7:0] ex [4];
        hs = '{1301, 1303, 1297, 1304};
        ex = '{8'd128, 8'd128, 8'd127, 8'd129};
        for (int k = 0; k < 4; k++) begin
            drive_pulse(hs[k], nv, ne, lat, ang, lv, nb);
            checks++; if (ang !== ex[k]) begin errors++; $display("FAIL round_angle h=%0d: got %0d expected %0d", hs[k], ang, ex[k]); end
            checks++; if (nv !== 1 || ne !== 0) begin errors++; $display("FAIL round_strobes h=%0d: got valid=%0d err=%0d expected 1/0", hs[k], nv, ne); end
        end
    endtask

    task automatic test_limits();
        drive_pulse(2240, nv, ne, lat, ang, lv, nb);
        checks++; if (ang !== 8'd255 || nv !== 1 || ne !== 0) begin errors++; $display("FAIL sat_2240: got angle=%0d valid=%0d err=%0d expected 255/1/0", ang, nv, ne); end
        drive_pulse(320, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 1 || nv !== 0) begin errors++; $display("FAIL short_320: got err=%0d valid=%0d expected 1/0", ne, nv); end
        checks++; if (ang !== 8'd255) begin errors++; $display("FAIL short_angle_hold: got %0d expected 255", ang); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL short_both: got %0d expected 0", nb); end
        drive_pulse(399, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 1 || nv !== 0) begin errors++; $display("FAIL short_399: got err=%0d valid=%0d expected 1/0", ne, nv); end
        drive_pulse(400, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 0 || nv !== 1 || ang !== 8'd0) begin errors++; $display("FAIL short_400: got err=%0d valid=%0d angle=%0d expected 0/1/0", ne, nv, ang); end
        drive_pulse(2400, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 0 || nv !== 1 || ang !== 8'd255) begin errors++; $display("FAIL long_2400: got err=%0d valid=%0d angle=%0d expected 0/1/255", ne, nv, ang); end
        drive_pulse(2401, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 1 || nv !== 0) begin errors++; $display("FAIL long_2401: got err=%0d valid=%0d expected 1/0", ne, nv); end
    endtask

    task automatic test_long_hold();
        int first = -1;
        int n_v = 0;
        int n_e = 0;
        servo_pwm = 1'b1;
        for (int n = 1; n <= 2560 + 12; n++) begin
            step();
            if (n == 2560) servo_pwm = 1'b0;
            if (pulse_err) n_e++;
            if (angle_valid) n_v++;
            if (pulse_err && first < 0) first = n;
        end
        // Pin edge reaches s after 2 cycles, error on high cycle 2401, registered one cycle later.
        checks++; if (first !== 2403) begin errors++; $display("FAIL hold_err_cycle: got %0d expected 2403", first); end
        checks++; if (n_e !== 1 || n_v !== 0) begin errors++; $display("FAIL hold_strobes: got err=%0d valid=%0d expected 1/0", n_e, n_v); end
        drive_pulse(593, nv, ne, lat, ang, lv, nb);
        checks++; if (ang !== 8'd10 || nv !== 1) begin errors++; $display("FAIL hold_recover: got angle=%0d valid=%0d expected 10/1", ang, nv); end
    endtask

    task automatic test_signal_lost();
        int found = -1;
        int n_v = 0;
        drive_pulse(533, nv, ne, lat, ang, lv, nb);
        repeat (17600 - 545) step();
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL lost_between_pulses: got %0b expected 0", signal_lost); end
        servo_pwm = 1'b1;
        for (int n = 1; n <= 20100; n++) begin
            step();
            if (n == 533) servo_pwm = 1'b0;
            if (angle_valid) n_v++;
            if (signal_lost) begin
                found = n;
                break;
            end
        end
        // Synchronized rise lands 2 cycles after the pin, timeout 20000 cycles after that.
        checks++; if (found !== 20002) begin errors++; $display("FAIL lost_timeout_cycle: got %0d expected 20002", found); end
        checks++; if (n_v !== 1) begin errors++; $display("FAIL lost_last_pulse_valid: got %0d expected 1", n_v); end
        drive_pulse(320, nv, ne, lat, ang, lv, nb);
        checks++; if (ne !== 1 || signal_lost !== 1'b1) begin errors++; $display("FAIL lost_kept_on_err: got err=%0d lost=%0b expected 1/1", ne, signal_lost); end
        drive_pulse(533, nv, ne, lat, ang, lv, nb);
        checks++; if (nv !== 1 || lv !== 1'b0 || signal_lost !== 1'b0) begin errors++; $display("FAIL lost_cleared: got valid=%0d lost_at_valid=%0b lost=%0b expected 1/0/0", nv, lv, signal_lost); end
    endtask

    task automatic test_reset_mid_pulse();
        int n_v = 0;
        int n_e = 0;
        drive_pulse(1301, nv, ne, lat, ang, lv, nb);
        servo_pwm = 1'b1;
        repeat (200) step();
        rst = 1'b1;
        step(); step(); step();
        checks++; if (angle !== 8'd0 || signal_lost !== 1'b1) begin errors++; $display("FAIL midrst_outputs: got angle=%0d lost=%0b expected 0/1", angle, signal_lost); end
        rst = 1'b0;
        for (int n = 1; n <= 600 + 12; n++) begin
            step();
            if (n == 600) servo_pwm = 1'b0;
            if (angle_valid) n_v++;
            if (pulse_err) n_e++;
        end
        checks++; if (n_v !== 0 || n_e !== 0) begin errors++; $display("FAIL midrst_ignored: got valid=%0d err=%0d expected 0/0", n_v, n_e); end
        drive_pulse(593, nv, ne, lat, ang, lv, nb);
        checks++; if (ang !== 8'd10 || nv !== 1) begin errors++; $display("FAIL midrst_next: got angle=%0d valid=%0d expected 10/1", ang, nv); end
    endtask

    // Driver encodes high time as MIN_PULSE + angle * CYCLES_PER_ANGLE.
    task automatic test_loopback();
        logic [7:0] codes [5];
        codes = '{8'd0, 8'd1, 8'd127, 8'd254, 8'd255};
        for (int k = 0; k < 5; k++) begin
            drive_pulse(533 + int'(codes[k]) * 6, nv, ne, lat, ang, lv, nb);
            checks++; if (ang !== codes[k] || nv !== 1 || nb !== 0) begin errors++; $display("FAIL loopback_%0d: got angle=%0d valid=%0d both=%0d expected %0d/1/0", codes[k], ang, nv, nb, codes[k]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        servo_pwm = 1'b0;
        test_reset();
        test_min_pulse();
        test_rounding();
        test_limits();
        test_long_hold();
        test_signal_lost();
        test_reset_mid_pulse();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
